// File: rtl/seq_mux_scan.sv
// Registered N-channel mux with select register, manual/scan modes,
// hold, and a blanking flag on every channel change.
//
// Ports:
//   clk, rst (sync, active-high)
//   din      : NCH packed channels, channel k at [k*WIDTH +: WIDTH]
//   mode     : 0 manual, 1 auto-scan
//   sel_in   : manual channel index
//   sel_load : load sel_in (strobe)
//   hold     : freeze all state
//   dout     : registered data of the pre-edge channel
//   sel_out  : select register
//   valid    : dout matches sel_out
//   sw_pulse : pulse the cycle after sel_out changes
//   err      : pulse after an out-of-range sel_load
module seq_mux_scan #(
  parameter int WIDTH = 8,
  parameter int NCH   = 8,
  parameter int SELW  = 3,
  parameter int DWELL = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic               mode,
  input  logic [SELW-1:0]    sel_in,
  input  logic               sel_load,
  input  logic               hold,
  output logic [WIDTH-1:0]   dout,
  output logic [SELW-1:0]    sel_out,
  output logic               valid,
  output logic               sw_pulse,
  output logic               err
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SELW:0]   NCH_L = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] LAST  = SELW'(NCH - 1);
  localparam logic [CW-1:0]   CMAX  = CW'(DWELL - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SELW-1:0]  sel_q;
  logic [SELW-1:0]  sel_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] mux;
  logic             chg_q;
  logic             ld_ok;
  logic             ld_bad;

  assign ld_ok  = sel_load && ({1'b0, sel_in} < NCH_L);
  assign ld_bad = sel_load && !ld_ok;

  always_comb begin
    mux = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel_q == SELW'(k)) begin
        mux = din[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MANUAL;
    end else if (!hold) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = mode ? SCAN : MANUAL;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    if (ld_ok) begin
      sel_d = sel_in;
      cnt_d = '0;
    end else if (!sel_load && state_q == SCAN
                 && state_d == SCAN) begin
      if (cnt_q == CMAX) begin
        cnt_d = '0;
        sel_d = (sel_q == LAST) ? '0
              : sel_q + SELW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // Entering or staying in manual keeps the dwell count parked at 0.
    if (state_q != state_d || state_d == MANUAL) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= '0;
      cnt_q    <= '0;
      dout     <= '0;
      valid    <= 1'b0;
      chg_q    <= 1'b0;
      sw_pulse <= 1'b0;
      err      <= 1'b0;
    end else if (!hold) begin
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      dout     <= mux;
      // dout still carries the old channel on the change edge.
      valid    <= (sel_d == sel_q);
      chg_q    <= (sel_d != sel_q);
      sw_pulse <= chg_q;
      err      <= ld_bad;
    end
  end

  assign sel_out = sel_q;

endmodule

// File: tb/tb_seq_mux_scan.sv
// Self-checking bench for seq_mux_scan: two instances (8ch/dwell 4 and
// 5ch/dwell 1), directed scenarios plus random traffic vs a model.
module tb_seq_mux_scan;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_mode, a_sel_load, a_hold;
  logic [63:0] a_din;
  logic [2:0]  a_sel_in, a_sel_out;
  logic [7:0]  a_dout;
  logic        a_valid, a_sw, a_err;

  logic        b_rst, b_mode, b_sel_load, b_hold;
  logic [39:0] b_din;
  logic [2:0]  b_sel_in, b_sel_out;
  logic [7:0]  b_dout;
  logic        b_valid, b_sw, b_err;

  seq_mux_scan #(
    .WIDTH(8), .NCH(8), .SELW(3), .DWELL(4)
  ) u_a (
    .clk(clk), .rst(a_rst), .din(a_din), .mode(a_mode),
    .sel_in(a_sel_in), .sel_load(a_sel_load), .hold(a_hold),
    .dout(a_dout), .sel_out(a_sel_out), .valid(a_valid),
    .sw_pulse(a_sw), .err(a_err)
  );

  seq_mux_scan #(
    .WIDTH(8), .NCH(5), .SELW(3), .DWELL(1)
  ) u_b (
    .clk(clk), .rst(b_rst), .din(b_din), .mode(b_mode),
    .sel_in(b_sel_in), .sel_load(b_sel_load), .hold(b_hold),
    .dout(b_dout), .sel_out(b_sel_out), .valid(b_valid),
    .sw_pulse(b_sw), .err(b_err)
  );

  int n_chk = 0;
  int n_err = 0;

  int nch[2]   = '{8, 5};
  int dwell[2] = '{4, 1};
  int m_scan[2], m_sel[2], m_cnt[2], m_dout[2];
  int m_valid[2], m_sw[2], m_err[2], m_chg[2];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: one call per rising edge.
  task automatic step(input int i, input bit r, input bit h,
                      input bit md, input bit ld, input int si,
                      input logic [63:0] d);
    int ns, nc;
    if (r) begin
      m_scan[i] = 0; m_sel[i] = 0; m_cnt[i] = 0; m_dout[i] = 0;
      m_valid[i] = 0; m_sw[i] = 0; m_err[i] = 0; m_chg[i] = 0;
    end else if (!h) begin
      ns = m_sel[i];
      nc = m_cnt[i];
      if (ld && si < nch[i]) begin
        ns = si;
        nc = 0;
      end else if (!ld && m_scan[i] != 0 && md) begin
        nc = nc + 1;
        if (nc == dwell[i]) begin
          nc = 0;
          ns = (ns + 1) % nch[i];
        end
      end
      if (!md || m_scan[i] == 0) nc = 0;
      m_err[i]   = (ld && si >= nch[i]) ? 1 : 0;
      m_dout[i]  = int'(d[m_sel[i]*8 +: 8]);
      m_valid[i] = (ns == m_sel[i]) ? 1 : 0;
      m_sw[i]    = m_chg[i];
      m_chg[i]   = (ns != m_sel[i]) ? 1 : 0;
      m_sel[i]   = ns;
      m_cnt[i]   = nc;
      m_scan[i]  = md ? 1 : 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    step(0, a_rst, a_hold, a_mode, a_sel_load, int'(a_sel_in), a_din);
    step(1, b_rst, b_hold, b_mode, b_sel_load, int'(b_sel_in),
         {24'd0, b_din});
    #1;
    chk("a_dout",  a_dout,    m_dout[0]);
    chk("a_sel",   a_sel_out, m_sel[0]);
    chk("a_valid", a_valid,   m_valid[0]);
    chk("a_sw",    a_sw,      m_sw[0]);
    chk("a_err",   a_err,     m_err[0]);
    chk("b_dout",  b_dout,    m_dout[1]);
    chk("b_sel",   b_sel_out, m_sel[1]);
    chk("b_valid", b_valid,   m_valid[1]);
    chk("b_sw",    b_sw,      m_sw[1]);
    chk("b_err",   b_err,     m_err[1]);
  endtask

  int scan_exp[12] = '{6, 6, 6, 6, 7, 7, 7, 7, 0, 0, 0, 0};
  int b_exp[6]     = '{0, 1, 2, 3, 4, 0};
  logic [7:0] held;

  initial begin
    a_rst = 1; a_mode = 0; a_sel_load = 0; a_hold = 0; a_sel_in = 0;
    b_rst = 1; b_mode = 0; b_sel_load = 0; b_hold = 0; b_sel_in = 0;
    for (int k = 0; k < 8; k++) a_din[k*8 +: 8] = 8'(16 + k);
    for (int k = 0; k < 5; k++) b_din[k*8 +: 8] = 8'(32 + k);

    tick();
    chk("rst_sel",   a_sel_out, 0);
    chk("rst_dout",  a_dout,    0);
    chk("rst_valid", a_valid,   0);
    a_rst = 0; b_rst = 0;
    tick();
    chk("first_dout",  a_dout,  32'h10);
    chk("first_valid", a_valid, 1);

    a_sel_load = 1; a_sel_in = 5;
    tick();
    a_sel_load = 0;
    chk("ld_sel",   a_sel_out, 5);
    chk("ld_blank", a_valid,   0);
    tick();
    chk("ld_dout",  a_dout,  32'h15);
    chk("ld_valid", a_valid, 1);
    chk("ld_sw",    a_sw,    1);

    a_sel_load = 1; a_sel_in = 6;
    tick();
    a_sel_load = 0;
    tick();
    tick();
    a_mode = 1;
    tick();
    for (int i = 0; i < 12; i++) begin
      chk("scan_seq", a_sel_out, scan_exp[i]);
      chk("scan_valid", a_valid, (i == 4 || i == 8) ? 0 : 1);
      tick();
    end

    tick();
    tick();
    held = a_dout;
    a_din[15:8] = 8'hEE;
    a_hold = 1;
    repeat (10) begin
      tick();
      chk("hold_sel",  a_sel_out, 1);
      chk("hold_dout", a_dout,    held);
    end
    a_hold = 0;
    tick();
    chk("rel_sel1", a_sel_out, 1);
    tick();
    chk("rel_sel2", a_sel_out, 2);
    a_din[15:8] = 8'h11;

    a_sel_load = 1; a_sel_in = 1;
    tick();
    a_sel_load = 0;
    repeat (3) tick();
    chk("pre_adv", a_sel_out, 1);
    a_sel_load = 1; a_sel_in = 3;
    tick();
    a_sel_load = 0;
    chk("ld_wins", a_sel_out, 3);
    repeat (3) tick();
    chk("ld_dwell", a_sel_out, 3);
    tick();
    chk("ld_next", a_sel_out, 4);

    a_hold = 1; a_sel_load = 1; a_sel_in = 2; a_rst = 1;
    tick();
    chk("mrst_sel",   a_sel_out, 0);
    chk("mrst_dout",  a_dout,    0);
    chk("mrst_valid", a_valid,   0);
    chk("mrst_sw",    a_sw,      0);
    a_rst = 0; a_hold = 0; a_sel_load = 0;
    tick();
    chk("mrst_first", a_dout, 32'h10);
    repeat (3) tick();
    chk("mrst_manual", a_sel_out, 0);
    tick();
    chk("mrst_scan", a_sel_out, 1);
    a_mode = 0;

    b_sel_load = 1; b_sel_in = 6;
    tick();
    b_sel_load = 0;
    chk("b_err_on",  b_err,     1);
    chk("b_err_sel", b_sel_out, 0);
    tick();
    chk("b_err_off", b_err, 0);
    b_sel_load = 1; b_sel_in = 4;
    tick();
    b_sel_load = 0;
    b_mode = 1;
    tick();
    chk("b_start", b_sel_out, 4);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("b_wrap", b_sel_out, b_exp[i]);
      chk("b_blank", b_valid, 0);
    end

    for (int n = 0; n < 400; n++) begin
      a_rst = ($urandom_range(0, 49) == 0);
      b_rst = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0) a_hold = ~a_hold;
      if ($urandom_range(0, 9) == 0) b_hold = ~b_hold;
      if ($urandom_range(0, 19) == 0) a_mode = ~a_mode;
      if ($urandom_range(0, 19) == 0) b_mode = ~b_mode;
      a_sel_load = ($urandom_range(0, 9) == 0);
      b_sel_load = ($urandom_range(0, 7) == 0);
      a_sel_in = 3'($urandom_range(0, 7));
      b_sel_in = 3'($urandom_range(0, 7));
      a_din = {$urandom, $urandom};
      b_din = {$urandom, 8'($urandom)};
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
